stoch_decode: RTL and testbench
===============================

// Module: stoch_decode
// PURPOSE
//  Converts a unipolar stochastic bitstream (e.g. the y output of the stochastic averager) to binary.
//  Counts ones over a window of 2**WINDOW_BITS accepted bits and presents the count on a valid/ready output.
//  The averager's output feeds a; the decoded count goes to the binary consumer (readout/CSR/next compute stage).
//  Encoded probability = y_data / 2**WINDOW_BITS.
// PARAMETERS
//  WINDOW_BITS  8  log2 of window length; window = 2**WINDOW_BITS accepted bits; y_data width = WINDOW_BITS+1
// PORTS
//  CLK      in   1              clock; all state updates on rising edge
//  nRST     in   1              reset; asynchronous, active-low
//  start    in   1              request a conversion; honoured only in IDLE, or in HOLD on the y_ready handshake cycle
//  a        in   1              stochastic bitstream input
//  a_en     in   1              qualifier; a is sampled only on cycles with a_en=1
//  y_data   out  WINDOW_BITS+1  ones count of the last completed window, range 0..2**WINDOW_BITS
//  y_valid  out  1              y_data valid; held until accepted
//  y_ready  in   1              consumer accepts y_data when y_valid && y_ready
//  busy     out  1              1 while in ACCUM
// BEHAVIOUR
//  Reset (nRST=0, async): state=IDLE; sample counter=0; ones accumulator=0; y_data=0; y_valid=0; busy=0.
//  FSM states: IDLE, ACCUM, HOLD.
//  IDLE: start=1 -> ACCUM; clear sample counter and accumulator. a is ignored in IDLE, including on the start cycle.
//  ACCUM:
//   - busy=1.
//   - Each cycle with a_en=1: accumulator += a; sample counter += 1.
//   - Cycles with a_en=0 change nothing.
//   - start is ignored.
//  Window end: on the accepted sample where the sample counter == 2**WINDOW_BITS-1:
//   - y_data <= accumulator + a, registered at that edge;
//   - y_valid=1 from the next cycle;
//   - state -> HOLD.
//  Latency: y_valid rises 1 cycle after the last accepted bit; minimum start-to-valid = 2**WINDOW_BITS+1 cycles.
//  HOLD:
//   - y_data and y_valid are stable until the handshake (y_valid && y_ready).
//   - a and a_en are ignored; bits presented in HOLD are dropped, not buffered.
//  Handshake cycle: y_valid drops on the next cycle.
//   - start=1 on that cycle -> ACCUM with counters cleared, so back-to-back windows have zero gap cycles after HOLD.
//   - otherwise -> IDLE.
//  y_data keeps the last value after acceptance; it changes only at the next window end.
//  Widths:
//   - sample counter is WINDOW_BITS wide and wraps to 0 only via the clear on entering ACCUM;
//   - accumulator is WINDOW_BITS+1 wide, so an all-ones window gives 2**WINDOW_BITS with no overflow.
//  Reset mid-operation (any state): immediate return to reset values; the partial window is discarded.
//  No combinational path from any input to any output; all outputs are registered.
// TESTING (WINDOW_BITS=4 unless noted)
//  1. start pulse; a=1, a_en=1 for 16 cycles; y_ready=1 -> y_valid on cycle 17 after start, y_data=16, busy=0 after.
//  2. a=0 for 16 bits -> y_data=0.
//     Alternating 1,0 for 16 bits -> y_data=8.
//  3. a_en pattern 1,0,0,1... (16 accepted bits, all a=1, a=1 also on gated cycles) -> y_data=16; valid only after the 16th accepted bit.
//  4. Backpressure: y_ready=0 for 10 cycles after y_valid while a toggles -> y_data/y_valid stable.
//     Then y_ready=1 with start=0 -> IDLE; y_valid=0 next cycle.
//  5. Back-to-back: y_ready=1 and start=1 on the handshake cycle; second window of 5 ones -> y_data=5.
//     No extra gap cycles; start asserted during ACCUM has no effect.
//  6. nRST low mid-ACCUM (after 7 samples), asynchronously between edges -> outputs 0 immediately.
//     Next start + 16 ones -> y_data=16 (no residue). Also WINDOW_BITS=1: 2 ones -> y_data=2.

Source files
------------

// File: rtl/stoch_decode.sv
// stoch_decode: counts ones over a 2**WINDOW_BITS-sample window of a stochastic bitstream and hands out the count on valid/ready
module stoch_decode #(
  parameter int WINDOW_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 a,
  input  logic                 a_en,
  output logic [WINDOW_BITS:0] y_data,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t                 state_q;
  logic [WINDOW_BITS-1:0] cnt_q;
  logic [WINDOW_BITS:0]   acc_q, acc_d, y_data_q;
  logic                   y_valid_q, busy_q;
  // accumulator including the bit accepted this cycle
  always_comb acc_d = acc_q + (WINDOW_BITS+1)'(a);
  // window FSM with registered outputs; HOLD drops incoming bits until the handshake
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= ACCUM;
          cnt_q   <= '0;
          acc_q   <= '0;
          busy_q  <= 1'b1;
        end
        ACCUM: if (a_en) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + WINDOW_BITS'(1);
          if (cnt_q == '1) begin
            y_data_q  <= acc_d;
            y_valid_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= HOLD;
          end
        end
        HOLD: if (y_ready) begin
          y_valid_q <= 1'b0;
          state_q   <= start ? ACCUM : IDLE;
          busy_q    <= start;
          cnt_q     <= '0;
          acc_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_stoch_decode.sv
// tb_stoch_decode: directed vector bench for stoch_decode (WINDOW_BITS=4, plus a WINDOW_BITS=1 instance)
module tb_stoch_decode;
  logic       clk = 1'b0;
  logic       n_rst, start, a, a_en, y_ready, y_valid, busy;
  logic [4:0] y_data;
  logic       start1, a1, a_en1, y_ready1, y_valid1, busy1;
  logic [1:0] y_data1;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  stoch_decode #(.WINDOW_BITS(4)) dut (
    .CLK(clk), .nRST(n_rst), .start(start), .a(a), .a_en(a_en),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
  );

  stoch_decode #(.WINDOW_BITS(1)) dut1 (
    .CLK(clk), .nRST(n_rst), .start(start1), .a(a1), .a_en(a_en1),
    .y_data(y_data1), .y_valid(y_valid1), .y_ready(y_ready1), .busy(busy1)
  );

  typedef struct {
    logic [15:0] bits;
    int          gap;
    logic [4:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // start pulse with a=1,a_en=1 on the same cycle; IDLE must ignore that bit
  task automatic begin_win();
    @(negedge clk);
    start = 1'b1; a = 1'b1; a_en = 1'b1;
  endtask

  // 16 accepted bits, each followed by gap gated cycles carrying a=1
  task automatic feed(input logic [15:0] bits, input int gap, input logic st);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_accum", busy, 1);
        y_ready = 1'b0;
      end
      if (i == 15) chk("valid_before_last", y_valid, 0);
      start = st; a = bits[i]; a_en = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (i < 15) chk("valid_gated", y_valid, 0);
        a = 1'b1; a_en = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0; a_en = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp);
    chk({name, "_valid"}, y_valid, 1);
    chk({name, "_data"}, y_data, exp);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic accept(input logic [4:0] exp);
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    chk("accept_valid", y_valid, 0);
    chk("accept_busy", busy, 0);
    chk("accept_keep", y_data, exp);
  endtask

  initial begin
    vec_t v[6];
    v[0] = '{16'hFFFF, 0, 5'd16};
    v[1] = '{16'h0000, 0, 5'd0};
    v[2] = '{16'hAAAA, 0, 5'd8};
    v[3] = '{16'hFFFF, 2, 5'd16};
    v[4] = '{16'h001F, 0, 5'd5};
    v[5] = '{16'h8001, 1, 5'd2};
    n_rst = 1'b0; start = 1'b0; a = 1'b0; a_en = 1'b0; y_ready = 1'b0;
    start1 = 1'b0; a1 = 1'b0; a_en1 = 1'b0; y_ready1 = 1'b0;
    #1;
    chk("rst_data", y_data, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      begin_win();
      feed(v[k].bits, v[k].gap, 1'b0);
      check_out($sformatf("vec%0d", k), v[k].exp);
      accept(v[k].exp);
    end
    // backpressure: HOLD ignores toggling a / a_en until accepted
    begin_win();
    feed(16'hFFFF, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = ~a; a_en = 1'b1;
      chk("bp_valid", y_valid, 1);
      chk("bp_data", y_data, 16);
    end
    a_en = 1'b0;
    accept(5'd16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 1'b1; a_en = 1'b1;
      chk("idle_busy", busy, 0);
      chk("idle_valid", y_valid, 0);
    end
    a_en = 1'b0;
    // back-to-back: start on the handshake cycle, start held during ACCUM
    begin_win();
    feed(16'h0F0F, 0, 1'b0);
    check_out("b2b_first", 5'd8);
    y_ready = 1'b1; start = 1'b1;
    feed(16'h001F, 0, 1'b1);
    check_out("b2b_second", 5'd5);
    accept(5'd5);
    // asynchronous reset mid-window discards the partial count
    begin_win();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0; a = 1'b1; a_en = 1'b1;
    end
    @(negedge clk);
    a_en = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("arst_data", y_data, 0);
    chk("arst_valid", y_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;
    begin_win();
    feed(16'hFFFF, 0, 1'b0);
    check_out("post_rst", 5'd16);
    accept(5'd16);
    // WINDOW_BITS=1: two ones fill the window completely
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'b1; a_en1 = 1'b1;
    chk("w1_busy", busy1, 1);
    @(negedge clk);
    chk("w1_valid_early", y_valid1, 0);
    @(negedge clk);
    a_en1 = 1'b0;
    chk("w1_valid", y_valid1, 1);
    chk("w1_data", y_data1, 2);
    y_ready1 = 1'b1;
    @(negedge clk);
    y_ready1 = 1'b0;
    chk("w1_accept", y_valid1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
